// File: rtl/alu_issue.sv
// Issues one ALU instruction at a time from an 8x8 register file and writes back the result or compare flag.
// Latency: accept at E0, alu_en in the cycle after E0, done in the cycle after E1, write visible after E2.
// Backpressure: instr_ready is high only in IDLE, so at most one instruction is accepted every 3 cycles.
module alu_issue (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] funct,
    input  logic [2:0] rd,
    input  logic [2:0] rs,
    input  logic       imm_sel,
    input  logic [7:0] imm,
    input  logic       wb_en,
    output logic       alu_en,
    output logic [7:0] alu_x,
    output logic [7:0] alu_y,
    output logic [3:0] alu_funct,
    input  logic [7:0] alu_result,
    input  logic       alu_cmp,
    output logic       cmp_flag,
    output logic       done,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_regs [8];
    logic [2:0] r_rd;
    logic       r_wb_en;
    logic       r_ready;
    logic       r_alu_en;
    logic       r_done;
    logic       r_cmp;
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic [3:0] r_funct;

    logic [7:0] w_y;
    logic       w_wb_write;
    logic       w_cmp_write;

    // Operand y is muxed before the acceptance edge; rd==rs naturally reads the same pre-write value.
    assign w_y         = imm_sel ? imm : r_regs[rs];
    assign w_wb_write  = (r_state == S_WB) &&  r_wb_en;
    assign w_cmp_write = (r_state == S_WB) && !r_wb_en;

    // Control FSM: captures the instruction on acceptance and sequences the registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_alu_en <= 1'b0;
            r_done   <= 1'b0;
            r_x      <= 8'h00;
            r_y      <= 8'h00;
            r_funct  <= 4'h0;
            r_rd     <= 3'd0;
            r_wb_en  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_state  <= S_EXEC;
                        r_ready  <= 1'b0;
                        r_alu_en <= 1'b1;
                        r_x      <= r_regs[rd];
                        r_y      <= w_y;
                        r_funct  <= funct;
                        r_rd     <= rd;
                        r_wb_en  <= wb_en;
                    end
                end
                S_EXEC: begin
                    r_state  <= S_WB;
                    r_alu_en <= 1'b0;
                    r_done   <= 1'b1;
                end
                S_WB: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_ready  <= 1'b1;
                    r_alu_en <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    // Register file and compare flag update only at the edge ending WB; reset aborts any pending update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_cmp <= 1'b0;
        end else begin
            if (w_wb_write) begin
                r_regs[r_rd] <= alu_result;
            end
            if (w_cmp_write) begin
                r_cmp <= alu_cmp;
            end
        end
    end

    assign instr_ready = r_ready;
    assign alu_en      = r_alu_en;
    assign done        = r_done;
    assign alu_x       = r_x;
    assign alu_y       = r_y;
    assign alu_funct   = r_funct;
    assign cmp_flag    = r_cmp;
    assign dbg_data    = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed instructions against a small behavioural ALU.
// Expected operands and writeback values are queued at issue and checked by a monitor on alu_en/done.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_alu_issue;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] funct;
    logic [2:0] rd;
    logic [2:0] rs;
    logic       imm_sel;
    logic [7:0] imm;
    logic       wb_en;
    logic       alu_en;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [3:0] alu_funct;
    logic [7:0] alu_result = 8'h00;
    logic       alu_cmp    = 1'b0;
    logic       cmp_flag;
    logic       done;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] f;
        logic [7:0] rv;
        logic       cf;
        logic       abort;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .funct       (funct),
        .rd          (rd),
        .rs          (rs),
        .imm_sel     (imm_sel),
        .imm         (imm),
        .wb_en       (wb_en),
        .alu_en      (alu_en),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_funct   (alu_funct),
        .alu_result  (alu_result),
        .alu_cmp     (alu_cmp),
        .cmp_flag    (cmp_flag),
        .done        (done),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 0101 add, 0100 subtract, anything else xor; equality flag alongside.
    always @(posedge clk) begin
        if (alu_en === 1'b1) begin
            case (alu_funct)
                4'b0101: alu_result <= alu_x + alu_y;
                4'b0100: alu_result <= alu_x - alu_y;
                default: alu_result <= alu_x ^ alu_y;
            endcase
            alu_cmp <= (alu_x == alu_y);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Monitor: pops one expectation per alu_en pulse and follows it through done and writeback.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (alu_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_issue: alu_en got 1 with no instruction outstanding, required 0");
                end else begin
                    passes++;
                    e = exp_q.pop_front();
                    chk("alu_x", alu_x, e.x);
                    chk("alu_y", alu_y, e.y);
                    chk("alu_funct", alu_funct, e.f);
                    chk("ready_in_exec", instr_ready, 0);
                    @(negedge clk);
                    chk("done_pulse", done, 1);
                    chk("alu_en_one_cycle", alu_en, 0);
                    chk("ready_in_wb", instr_ready, 0);
                    @(negedge clk);
                    chk("done_clear", done, 0);
                    chk("wb_reg", dbg_data, e.rv);
                    chk("cmp_flag", cmp_flag, e.cf);
                    if (!e.abort) begin
                        chk("alu_x_hold", alu_x, e.x);
                        chk("alu_y_hold", alu_y, e.y);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [3:0] f, input logic [2:0] d, input logic [2:0] s,
                         input logic is, input logic [7:0] im, input logic we,
                         input logic [7:0] ex, input logic [7:0] ey,
                         input logic [7:0] erv, input logic ecf);
        int n;
        n = 0;
        @(negedge clk);
        while (instr_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", instr_ready, 1);
        funct = f; rd = d; rs = s; imm_sel = is; imm = im; wb_en = we; dbg_addr = d;
        exp_q.push_back('{ex, ey, f, erv, ecf, 1'b0});
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [8:0] pat;
        int n;
        rst_n = 1'b0; instr_valid = 1'b1; funct = 4'h5; rd = 3'd1; rs = 3'd0;
        imm_sel = 1'b1; imm = 8'hEE; wb_en = 1'b1; dbg_addr = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_alu_en", alu_en, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", instr_ready, 1);
        chk("rst_cmp", cmp_flag, 0);
        chk("rst_alu_x", alu_x, 0);
        chk("rst_alu_y", alu_y, 0);
        chk("rst_alu_funct", alu_funct, 0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1 chk("rst_dbg_sweep", dbg_data, 0);
        end
        rst_n = 1'b1;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", instr_ready, 1);
        chk("post_rst_no_issue", alu_en, 0);

        // f,   rd, rs, imm_sel, imm, wb_en,  exp x, exp y, exp reg, exp cmp
        issue(4'b0101, 3'd1, 3'd0, 1'b1, 8'h05, 1'b1, 8'h00, 8'h05, 8'h05, 1'b0);
        issue(4'b0101, 3'd2, 3'd0, 1'b1, 8'h03, 1'b1, 8'h00, 8'h03, 8'h03, 1'b0);
        issue(4'b0100, 3'd1, 3'd2, 1'b0, 8'h00, 1'b1, 8'h05, 8'h03, 8'h02, 1'b0);
        issue(4'b0101, 3'd1, 3'd1, 1'b0, 8'h00, 1'b1, 8'h02, 8'h02, 8'h04, 1'b0);
        issue(4'b0101, 3'd3, 3'd0, 1'b1, 8'h07, 1'b1, 8'h00, 8'h07, 8'h07, 1'b0);
        issue(4'b0101, 3'd3, 3'd0, 1'b1, 8'h07, 1'b0, 8'h07, 8'h07, 8'h07, 1'b1);
        issue(4'b0101, 3'd3, 3'd0, 1'b1, 8'h08, 1'b0, 8'h07, 8'h08, 8'h07, 1'b0);
        issue(4'b1111, 3'd6, 3'd0, 1'b1, 8'hA5, 1'b1, 8'h00, 8'hA5, 8'hA5, 1'b0);
        issue(4'b1010, 3'd6, 3'd0, 1'b1, 8'h0F, 1'b1, 8'hA5, 8'h0F, 8'hAA, 1'b0);

        // Continuous instr_valid: three compares on reg5, acceptance every third edge.
        @(negedge clk);
        funct = 4'h3; rd = 3'd5; rs = 3'd0; imm_sel = 1'b1; imm = 8'h00; wb_en = 1'b0; dbg_addr = 3'd5;
        for (int i = 0; i < 3; i++) exp_q.push_back('{8'h00, 8'h00, 4'h3, 8'h00, 1'b1, 1'b0});
        instr_valid = 1'b1;
        pat = '0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            pat = {pat[7:0], instr_ready};
        end
        instr_valid = 1'b0;
        chk("ready_pattern", pat, 9'b001001001);
        repeat (3) @(negedge clk);

        // Reset during WB of a write to reg4 aborts the write.
        funct = 4'b0101; rd = 3'd4; imm_sel = 1'b1; imm = 8'h44; wb_en = 1'b1; dbg_addr = 3'd4;
        exp_q.push_back('{8'h00, 8'h44, 4'b0101, 8'h00, 1'b0, 1'b1});
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("abort_done_seen", done, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", instr_ready, 1);
        chk("abort_alu_en", alu_en, 0);
        rst_n = 1'b1;
        @(negedge clk);
        dbg_addr = 3'd1;
        #1 chk("abort_reg1_cleared", dbg_data, 0);

        issue(4'b0101, 3'd1, 3'd0, 1'b1, 8'h09, 1'b1, 8'h00, 8'h09, 8'h09, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
REQ-004 instr_valid  input  1  upstream presents an instruction this cycle.
REQ-005 instr_ready  output  1  block can accept an instruction this cycle.
REQ-006 funct  input  4  ALU function code, passed through unmodified.
REQ-007 rd  input  3  destination register and x-operand source.
REQ-008 rs  input  3  y-operand source register when imm_sel=0.
REQ-009 imm_sel  input  1  1 = y operand from imm, 0 = from reg[rs].
REQ-010 imm  input  8  immediate y operand.
REQ-011 wb_en  input  1  1 = write result to reg[rd]; 0 = update cmp_flag only.
REQ-012 alu_en  output  1  ALU enable, one-cycle pulse per instruction.
REQ-013 alu_x, alu_y  output  8 each  ALU operands.
REQ-014 alu_funct  output  4  ALU function code.
REQ-015 alu_result  input  8  ALU result, registered by the ALU on the edge ending the alu_en cycle.
REQ-016 alu_cmp  input  1  ALU equality flag, same timing as alu_result.
REQ-017 cmp_flag  output  1  last captured compare flag.
REQ-018 done  output  1  one-cycle pulse in the writeback cycle.
REQ-019 dbg_addr  input  3 / dbg_data  output  8  combinational register-file read port.

Function
REQ-020 Block SHALL contain an 8-entry x 8-bit register file, written only by this block.
REQ-021 FSM states SHALL be IDLE, EXEC, WB; IDLE->EXEC on instr_valid&&instr_ready, EXEC->WB unconditionally, WB->IDLE unconditionally.
REQ-022 instr_ready SHALL be 1 only in IDLE; inputs SHALL be ignored in all other states.
REQ-023 On acceptance edge, block SHALL register alu_x=reg[rd], alu_y=(imm_sel?imm:reg[rs]), alu_funct=funct, rd and wb_en.
REQ-024 alu_x, alu_y, alu_funct SHALL hold stable from acceptance edge until the next acceptance or reset.
REQ-025 alu_en SHALL be 1 exactly in EXEC, 0 otherwise.
REQ-026 done SHALL be 1 exactly in WB, 0 otherwise.
REQ-027 In WB with wb_en=1, reg[rd] SHALL take alu_result at the edge ending WB; cmp_flag unchanged.
REQ-028 In WB with wb_en=0, cmp_flag SHALL take alu_cmp at the edge ending WB; no register written.
REQ-029 Latency: accepted at edge E0 -> alu_en high cycle after E0 -> done high cycle after E1 -> write visible on dbg_data after E2.
REQ-030 Throughput SHALL be one instruction per 3 cycles; next acceptance earliest at E3.
REQ-031 rd==rs SHALL read the same pre-write value for both operands.
REQ-032 Back-to-back dependent instructions SHALL see prior writeback (no hazard, serialized by FSM).
REQ-033 funct values SHALL not be decoded; unknown codes pass through.
REQ-034 dbg_data SHALL equal reg[dbg_addr] combinationally.

Reset
REQ-035 rst_n=0 at an edge SHALL force IDLE, all registers 0, cmp_flag=0, alu_x=alu_y=0, alu_funct=0.
REQ-036 During and after reset: alu_en=0, done=0, instr_ready=1 the cycle after rst_n returns 1.
REQ-037 Reset in EXEC or WB SHALL abort the instruction with no register or cmp_flag update.
REQ-038 instr_valid asserted in the same cycle as rst_n=0 SHALL not be accepted.

Verification
REQ-039 Reset, then dbg_addr sweep 0..7 -> all dbg_data=0, cmp_flag=0, instr_ready=1.
REQ-040 Load reg1: imm_sel=1, imm=0x05, rd=1, funct=0101, wb_en=1 with model ALU -> alu_x=0x00, alu_y=0x05, alu_en pulse 1 cycle, done next cycle, reg1=0x05 after E2.
REQ-041 reg1=0x05, reg2=0x03; rd=1, rs=2, funct=0100, wb_en=1 -> reg1=0x02; then rd=1,rs=1 funct=0101 -> alu_x=alu_y=0x02, reg1=0x04.
REQ-042 Compare: reg3=0x07, imm=0x07, imm_sel=1, rd=3, wb_en=0, alu_cmp=1 -> cmp_flag=1, reg3 still 0x07; repeat imm=0x08, alu_cmp=0 -> cmp_flag=0.
REQ-043 instr_valid held high continuously -> acceptances exactly every 3 cycles, instr_ready low in EXEC/WB.
REQ-044 rst_n=0 during WB of a write to reg4 -> reg4=0, done=0 next cycle, state IDLE.
